univ_shift_reg_param: RTL

Parametrised universal shift register, the next generation of the team's 8-bit shift/load block. Adds the following over the fixed-width version:
- WIDTH generalisation
- clock enable
- rotate modes
- registered serial output
- framed serial-in/parallel-out (SIPO) capture with a frame-valid strobe
- framed parallel-in/serial-out (PISO) transmit with a busy flag

It sits between serial peripherals (UART/SPI-style bit streams) and byte/word datapaths on the FPGA fabric.

---
 rtl/usr_pkg.sv | 34 +++
 rtl/usr_bit_counter.sv | 38 +++
 rtl/univ_shift_reg_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared types for the parametrised universal shift register.
//   usr_mode_t   : 3-bit operation select, fully decoded (8 values).
//   piso_state_t : PISO transmit FSM states.
//   usr_ctrl_t   : registered control state (last enabled mode + PISO FSM
//                  state), kept as one struct so checkers can bind to it.
// ---------------------------------------------------------------------------
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    LOAD = 3'b011,
    ROR  = 3'b100,
    ROL  = 3'b101,
    SIPO = 3'b110,
    PISO = 3'b111
  } usr_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  typedef struct packed {
    usr_mode_t   last_mode;
    piso_state_t piso_state;
  } usr_ctrl_t;

  localparam usr_ctrl_t CTRL_RESET = '{last_mode: HOLD, piso_state: IDLE};

endpackage

// File: rtl/usr_bit_counter.sv
// ---------------------------------------------------------------------------
// usr_bit_counter
// Modulo-N bit counter shared by the SIPO and PISO frame logic.
//   clk   : system clock
//   reset : asynchronous active-low reset (count -> 0)
//   en    : count this cycle
//   clr   : synchronous restart of the count
//   tc    : terminal count, high while count == N-1
// A clear together with en restarts the frame and counts the current cycle
// as its first bit, so the count becomes 1; a clear alone gives 0.
// ---------------------------------------------------------------------------
module usr_bit_counter #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] count;

  assign tc = (count == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= en ? CW'(1) : '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/univ_shift_reg_param.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_param
// Parametrised universal shift register with rotate, framed SIPO capture and
// framed PISO transmit.
//
// Parameters:
//   WIDTH       : register width, 2..64
//   RESET_VALUE : value of q and the internal shift register after reset
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   en           in   clock enable; 0 freezes all state and zeroes strobes
//   mode         in   3-bit operation select (usr_mode_t)
//   serial_in    in   serial data input
//   parallel_in  in   parallel data input (WIDTH)
//   q            out  registered parallel output (WIDTH)
//   serial_out   out  registered serial output
//   frame_valid  out  one-cycle strobe at completion of a SIPO/PISO frame
//   busy         out  high while a PISO frame is in flight
//   frame_parity out  (only with USR_PARITY_EN) XOR of the completed frame,
//                     updated together with frame_valid
//
// Optional feature macro: USR_PARITY_EN. When defined, a PISO frame appends
// one even-parity bit on serial_out (busy stays high) before frame_valid.
//
// Handshake: there is no back-pressure. frame_valid is a pure strobe, high
// for exactly one clock after the edge that completes a frame; a consumer
// must sample q / frame_parity in that cycle.
//
// Any enabled edge whose mode differs from the previous enabled mode drops a
// partial frame (counter restart, PISO FSM to IDLE, busy low) and still
// performs the new mode's operation on that edge.
// ---------------------------------------------------------------------------
module univ_shift_reg_param
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             frame_valid,
  output logic             busy
`ifdef USR_PARITY_EN
  ,
  output logic             frame_parity
`endif
);

  usr_mode_t        cur_mode;
  usr_ctrl_t        ctrl_q;
  usr_ctrl_t        ctrl_d;
  piso_state_t      piso_st;

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] sipo_word;
  logic             so_d;
  logic             busy_d;
  logic             fv_d;
  logic             mode_chg;
  logic             last_bit;
  logic             cnt_en;
  logic             cnt_clr;
  logic             cnt_tc;

`ifdef USR_PARITY_EN
  logic             fp_d;
  logic             tx_par;
  logic             tx_par_d;
  logic             par_phase;
  logic             par_phase_d;
`endif

  assign cur_mode  = usr_mode_t'(mode);
  assign sipo_word = {shreg[WIDTH-2:0], serial_in};

  usr_bit_counter #(
    .N (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .tc    (cnt_tc)
  );

  // Next-state / output logic for the datapath and the PISO FSM.
  always_comb begin
    q_d      = q;
    shreg_d  = shreg;
    so_d     = serial_out;
    busy_d   = busy;
    fv_d     = 1'b0;
    ctrl_d   = ctrl_q;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    mode_chg = 1'b0;
    piso_st  = ctrl_q.piso_state;
    last_bit = 1'b0;
`ifdef USR_PARITY_EN
    fp_d        = frame_parity;
    tx_par_d    = tx_par;
    par_phase_d = par_phase;
`endif

    if (en) begin
      mode_chg         = (cur_mode != ctrl_q.last_mode);
      ctrl_d.last_mode = cur_mode;
      // A mode change behaves as if the frame had just been reset.
      piso_st          = mode_chg ? IDLE : ctrl_q.piso_state;
      last_bit         = cnt_tc && !mode_chg;
      cnt_clr          = mode_chg;
      busy_d           = 1'b0;
      ctrl_d.piso_state = IDLE;
`ifdef USR_PARITY_EN
      par_phase_d = 1'b0;
`endif

      case (cur_mode)
        HOLD: begin
        end
        SHR: begin
          q_d  = {serial_in, q[WIDTH-1:1]};
          so_d = q[0];
        end
        SHL: begin
          q_d  = {q[WIDTH-2:0], serial_in};
          so_d = q[WIDTH-1];
        end
        LOAD: begin
          q_d = parallel_in;
        end
        ROR: begin
          q_d = {q[0], q[WIDTH-1:1]};
        end
        ROL: begin
          q_d = {q[WIDTH-2:0], q[WIDTH-1]};
        end
        SIPO: begin
          shreg_d = sipo_word;
          cnt_en  = 1'b1;
          if (last_bit) begin
            q_d  = sipo_word;
            fv_d = 1'b1;
`ifdef USR_PARITY_EN
            fp_d = ^sipo_word;
`endif
          end
        end
        PISO: begin
          busy_d = 1'b1;
          if (piso_st == IDLE) begin
            // Frame start: the MSB goes out on this same edge.
            shreg_d           = parallel_in;
            so_d              = parallel_in[WIDTH-1];
            cnt_clr           = 1'b1;
            ctrl_d.piso_state = SHIFT;
`ifdef USR_PARITY_EN
            tx_par_d = ^parallel_in;
`endif
          end
`ifdef USR_PARITY_EN
          else if (last_bit && !par_phase) begin
            // Data exhausted; spend one extra cycle on the parity bit.
            so_d              = tx_par;
            par_phase_d       = 1'b1;
            ctrl_d.piso_state = SHIFT;
          end
`endif
          else if (last_bit) begin
            // Last bit has had its cycle; close the frame. The counter
            // increment wraps it back to 0.
            busy_d = 1'b0;
            fv_d   = 1'b1;
            cnt_en = 1'b1;
`ifdef USR_PARITY_EN
            fp_d = tx_par;
`endif
          end else begin
            shreg_d           = {shreg[WIDTH-2:0], 1'b0};
            so_d              = shreg[WIDTH-2];
            cnt_en            = 1'b1;
            ctrl_d.piso_state = SHIFT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q           <= RESET_VALUE;
      shreg       <= RESET_VALUE;
      serial_out  <= 1'b0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      ctrl_q      <= CTRL_RESET;
    end else begin
      q           <= q_d;
      shreg       <= shreg_d;
      serial_out  <= so_d;
      busy        <= busy_d;
      frame_valid <= fv_d;
      ctrl_q      <= ctrl_d;
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_parity <= 1'b0;
      tx_par       <= 1'b0;
      par_phase    <= 1'b0;
    end else begin
      frame_parity <= fp_d;
      tx_par       <= tx_par_d;
      par_phase    <= par_phase_d;
    end
  end
`endif

endmodule
